mac_window_stream: RTL

- Parametrised successor of the fixed 3-sample a*b+c stream unit.
- Collects a sliding window of WIN consecutive valid samples and computes the oldest two samples' product, combined with the remaining samples under a runtime-selectable mode.
- Adds configurable width and window length, an accumulate mode, and saturate-or-wrap arithmetic with an overflow flag.
- Sits in the datapath between a valid-qualified sample source and a downstream consumer; the output is registered.

---
 rtl/mac_window_stream.sv | 113 +++++++++++
 1 files changed

// File: rtl/mac_window_stream.sv
// Sliding-window multiply/accumulate stream unit: oldest two samples multiplied,
// remaining window samples combined per mode, result registered with wrap/saturate.
module mac_window_stream #(
  parameter int DW  = 8,
  parameter int OW  = 8,
  parameter int WIN = 3,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          validi,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    mode,
  input  logic          acc_clr,
  output logic          valido,
  output logic [OW-1:0] data_out,
  output logic          ovf
);

  localparam int CW = $clog2(WIN + 1);
  localparam int IW = 2 * DW + $clog2(WIN) + OW + 2;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ACC = 2'd2,
    MODE_MUL = 2'd3
  } mode_e;

  // Only WIN-1 samples are stored; the newest window sample is data_in itself.
  logic [DW-1:0] sr_q [WIN-1];
  logic [CW-1:0] cnt_q;
  logic [OW-1:0] acc_q;

  logic [DW-1:0] win [WIN];
  logic [IW-1:0] prod;
  logic [IW-1:0] sum;
  logic [IW-1:0] acc_term;
  logic [IW-1:0] r;
  logic          fire;
  logic          neg;
  logic          ovf_c;
  logic [OW-1:0] res;

  always_comb begin
    for (int unsigned i = 0; i < WIN - 1; i++) begin
      win[i] = sr_q[i];
    end
    win[WIN-1] = data_in;
  end

  assign fire = validi && (cnt_q >= CW'(WIN - 1));

  // Unsigned modular arithmetic in a width wide enough that the top bit is a true sign.
  always_comb begin
    prod     = IW'(win[0]) * IW'(win[1]);
    sum      = '0;
    for (int unsigned i = 2; i < WIN; i++) begin
      sum = sum + IW'(win[i]);
    end
    acc_term = acc_clr ? '0 : IW'(acc_q);
    r        = prod;
    case (mode_e'(mode))
      MODE_ADD: r = prod + sum;
      MODE_SUB: r = prod - sum;
      MODE_ACC: r = acc_term + prod + sum;
      MODE_MUL: r = prod;
      default:  r = prod;
    endcase
    neg   = r[IW-1];
    ovf_c = neg | (|r[IW-2:OW]);
    res   = r[OW-1:0];
    if (ovf_c && (SAT != 0)) begin
      res = neg ? '0 : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIN - 1; i++) begin
        sr_q[i] <= '0;
      end
      cnt_q    <= '0;
      acc_q    <= '0;
      valido   <= 1'b0;
      data_out <= '0;
      ovf      <= 1'b0;
    end else begin
      if (validi) begin
        for (int unsigned i = 0; i < WIN - 2; i++) begin
          sr_q[i] <= sr_q[i+1];
        end
        sr_q[WIN-2] <= data_in;
        cnt_q       <= (cnt_q == CW'(WIN)) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end

      valido <= fire;
      if (fire) begin
        data_out <= res;
        ovf      <= ovf_c;
      end

      if (fire && (mode_e'(mode) == MODE_ACC)) begin
        acc_q <= res;
      end else if (acc_clr) begin
        acc_q <= '0;
      end
    end
  end

endmodule
